// File: rtl/tile_sprite_writer_pkg.sv
// tile_palette_pkg: tile geometry, the fixed 7-entry tile palette and writer FSM states,
// shared with the tile readers so encode and decode use one palette.
package tile_palette_pkg;
  localparam int TILE_PIXELS = 400;
  localparam int ADDR_W = 9;
  localparam int IDX_W = 4;
  localparam int COLOR_W = 24;
  localparam int PAL_ENTRIES = 7;
  localparam logic [COLOR_W-1:0] PAL [PAL_ENTRIES] = '{
    24'h800080, 24'h000000, 24'h6E2601, 24'hB24204,
    24'hE85C0C, 24'hFF6F0B, 24'hFFE7C8
  };
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
endpackage

// File: rtl/tile_sprite_writer_if.sv
// tile_sprite_writer_if: pixel stream in, RAM write port and load status out.
interface tile_sprite_writer_if import tile_palette_pkg::*; ();
  logic start;
  logic pix_valid;
  logic pix_ready;
  logic [COLOR_W-1:0] pix_color;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0] wr_data;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] unmatched_count;
  modport master (
    output start, pix_valid, pix_color,
    input pix_ready, wr_en, wr_addr, wr_data, busy, done, unmatched_count
  );
  modport slave (
    input start, pix_valid, pix_color,
    output pix_ready, wr_en, wr_addr, wr_data, busy, done, unmatched_count
  );
endinterface

// File: rtl/tile_sprite_writer_palette_encoder.sv
// palette_encoder: maps a 24-bit color to its palette index; no match gives 0 with matched low.
module palette_encoder import tile_palette_pkg::*; (
  input  logic [COLOR_W-1:0] color,
  output logic [IDX_W-1:0]   idx,
  output logic               matched
);
  // Scanning downward lets the lowest matching entry overwrite the others.
  always_comb begin
    idx = '0;
    matched = 1'b0;
    for (int i = PAL_ENTRIES - 1; i >= 0; i--)
      if (color == PAL[i]) begin
        idx = IDX_W'(i);
        matched = 1'b1;
      end
  end
endmodule

// File: rtl/tile_sprite_writer.sv
// tile_sprite_writer: streams one 20x20 tile of RGB pixels into tile RAM as palette
// indices at addresses 0..TILE_PIXELS-1, counting pixels that match no palette entry.
module tile_sprite_writer import tile_palette_pkg::*; (
  input logic Clk,
  input logic Reset_n,
  tile_sprite_writer_if.slave bus
);
  state_t state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic matched, accept, last;
  palette_encoder u_enc (.color(bus.pix_color), .idx(idx), .matched(matched));
  assign accept = bus.pix_valid & bus.pix_ready;
  assign last = cnt == ADDR_W'(TILE_PIXELS - 1);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE ? (bus.start ? LOAD : IDLE)
               : state == LOAD ? (accept && last ? DONE : LOAD)
               : IDLE;
  end
  always_comb begin
    bus.pix_ready = state == LOAD;
  end
  // Write port, done and busy are registered so the RAM sees a clean one-cycle-late write.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.unmatched_count <= '0;
      cnt <= '0;
    end else begin
      bus.wr_en <= accept;
      bus.done <= accept && last;
      bus.busy <= state_next != IDLE;
      if (accept) begin
        bus.wr_addr <= cnt;
        bus.wr_data <= idx;
      end
      if (state == IDLE && bus.start) begin
        cnt <= '0;
        bus.unmatched_count <= '0;
      end else if (accept) begin
        cnt <= cnt + ADDR_W'(1);
        bus.unmatched_count <= bus.unmatched_count + ADDR_W'(!matched);
      end
    end
endmodule
